commit_watchdog: RTL
====================

// Module: commit_watchdog
// PURPOSE
// Synthesizable run monitor for the multi-issue CPU bench. Replaces ad-hoc bench-level order, timeout and halt logic.
// Tracks retirement order over NUM_CH commit channels, detects halt and stalls, and checks the memory handshake.
// Emits a sticky first-error code plus a run-done flag. Sits beside the DUT in mp top; feeds rvfi_order/halt to the monitor.
// PARAMETERS
// NUM_CH       2          commit channels per cycle (1..4), channel 0 oldest
// ORDER_W      64         width of retirement order counter
// TIMEOUT      100000000  max cycles with no commit before ERR_WATCHDOG (counter 32b)
// MEM_TIMEOUT  1024       max cycles a mem request may wait for mem_resp (counter 16b)
// DRAIN        30         cycles between first error and done
// PORTS
// clk              in   1                 clock, all state on posedge
// rst_n            in   1                 asynchronous, active-low reset
// commit           in   NUM_CH            channel i retires an instruction this cycle
// halt_req         in   NUM_CH            channel i retiring insn is self-loop (pc_rdata==pc_wdata)
// mem_read         in   1                 memory read request
// mem_write        in   1                 memory write request
// mem_resp         in   1                 memory response, 1-cycle pulse
// mem_address      in   32                request address
// mem_wdata        in   32                write data
// mem_byte_enable  in   4                 write byte mask
// order            out  NUM_CH*ORDER_W    order tag of channel i (valid when commit[i])
// halt             out  1                 sticky, retirement of a halt_req insn seen
// errcode          out  4                 first error code, sticky; 0 = none
// done             out  1                 sticky; end simulation
// BEHAVIOUR
// - Reset: order_base=0, order=0, halt=0, errcode=0, done=0, idle/mem/drain counters=0, mem FSM IDLE.
// - Order: order[i] = order_base + popcount(commit[i-1:0]) (combinational). order_base += popcount(commit) each cycle, mod 2^ORDER_W.
// - Commits must be contiguous from ch0: commit[i]&~commit[i-1] -> ERR_COMMIT_GAP.
// - Halt: halt<=1 when any commit[i]&halt_req[i]. Once halt=1: order_base frozen and done<=1 next cycle (1-cycle latency).
// - Watchdog: idle counter cleared on any commit, else +1; idle==TIMEOUT-1 with no commit -> ERR_WATCHDOG. Counting stops once halt or errcode!=0.
// - Mem FSM (sub-module):
//   - IDLE: read -> RD_WAIT, write -> WR_WAIT; latch addr, wdata, be.
//   - RD_WAIT/WR_WAIT: mem_resp -> IDLE. If request drops or addr/wdata/be change before resp -> ERR_REQ_UNSTABLE.
//   - Wait counter reaching MEM_TIMEOUT -> ERR_MEM_TIMEOUT.
//   - mem_resp in IDLE -> ERR_SPURIOUS_RESP. mem_read&mem_write any state -> ERR_RW_BOTH; FSM stays/returns IDLE.
//   - Resp and new request in the same cycle: the new request is accepted on the following cycle.
// - Errors: errcode captures first nonzero, never overwritten; same-cycle multiple -> lowest code wins. Drain counter starts; done<=1 when it hits DRAIN.
// - Both halt and error: done asserts at the earlier of the two.
// - rst_n low mid-run clears everything asynchronously. No events are recorded while rst_n is low.
// STRUCTURE
// - Package monitor_pkg: typedef enum logic[3:0] errcode_t {ERR_NONE=0, ERR_RW_BOTH=1, ERR_SPURIOUS_RESP=2,
//   ERR_REQ_UNSTABLE=3, ERR_MEM_TIMEOUT=4, ERR_COMMIT_GAP=5, ERR_WATCHDOG=6}; enum mem_state_t {IDLE,RD_WAIT,WR_WAIT}.
// - Sub-module mem_proto_checker: mem FSM + wait counter, outputs per-cycle error vector.
// - Top: order, watchdog, halt, error arbitration, drain.
// TESTING
// 1. NUM_CH=2, commit=11,01,11 on consecutive cycles -> order (0,1),(2,-),(3,4); order_base=5.
// 2. commit=10 (ch1 only) -> errcode=5; done exactly DRAIN(30) cycles later.
// 3. commit[0]&halt_req[0] at cycle 10 -> halt=1 at cycle 11; done=1 at cycle 12; errcode=0.
// 4. mem_read=1 @0x100, address changed to 0x104 before resp -> errcode=3. Separate run: mem_read&mem_write together -> errcode=1.
// 5. mem_resp pulse with no request -> errcode=2. Separate run: MEM_TIMEOUT=8, read held 8 cycles with no resp -> errcode=4.
// 6. TIMEOUT=16, no commits after reset -> errcode=6. Then drop rst_n mid-drain -> all outputs 0 immediately.

Source files
------------

// File: rtl/commit_watchdog_pkg.sv
// monitor_pkg: error codes, memory FSM states and first-error priority helper
package monitor_pkg;
    typedef enum logic [3:0] {
        ERR_NONE          = 4'd0,
        ERR_RW_BOTH       = 4'd1,
        ERR_SPURIOUS_RESP = 4'd2,
        ERR_REQ_UNSTABLE  = 4'd3,
        ERR_MEM_TIMEOUT   = 4'd4,
        ERR_COMMIT_GAP    = 4'd5,
        ERR_WATCHDOG      = 4'd6
    } errcode_t;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} mem_state_t;

    function automatic errcode_t first_err(input logic [6:1] v);
        errcode_t e;
        e = ERR_NONE;
        for (int i = 6; i >= 1; i--) if (v[i]) e = errcode_t'(4'(i));
        return e;
    endfunction
endpackage

// File: rtl/commit_watchdog_mem_proto_checker.sv
// mem_proto_checker: memory handshake FSM with wait counter; flags per-cycle protocol errors (bits 1..4)
module mem_proto_checker
    import monitor_pkg::*;
#(
    parameter int MEM_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_resp,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic [4:1]  errs
);
    mem_state_t  state;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [15:0] cnt;
    logic        waiting, both, req, changed, unstable, tmo, spur;

    // write data and mask only matter while a write is outstanding
    always_comb begin
        waiting  = state != IDLE;
        both     = mem_read & mem_write;
        req      = state == RD_WAIT ? mem_read : mem_write;
        changed  = mem_address != addr_q ||
                   (state == WR_WAIT && (mem_wdata != wdata_q || mem_byte_enable != be_q));
        unstable = waiting && !mem_resp && (!req || changed);
        tmo      = waiting && !mem_resp && cnt == 16'(MEM_TIMEOUT - 1);
        spur     = !waiting && mem_resp;
        errs     = {tmo, unstable, spur, both};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt     <= '0;
        end else if (both) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (!waiting) begin
            if (mem_read || mem_write) begin
                state   <= mem_read ? RD_WAIT : WR_WAIT;
                addr_q  <= mem_address;
                wdata_q <= mem_wdata;
                be_q    <= mem_byte_enable;
                cnt     <= 16'd1;
            end
        end else if (mem_resp || unstable || tmo) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end
endmodule

// File: rtl/commit_watchdog.sv
// commit_watchdog: retirement order tagging, halt detection, commit watchdog and sticky first-error/done reporting
module commit_watchdog
    import monitor_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ORDER_W     = 64,
    parameter int TIMEOUT     = 100000000,
    parameter int MEM_TIMEOUT = 1024,
    parameter int DRAIN       = 30
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         commit,
    input  logic [NUM_CH-1:0]         halt_req,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic                      mem_resp,
    input  logic [31:0]               mem_address,
    input  logic [31:0]               mem_wdata,
    input  logic [3:0]                mem_byte_enable,
    output logic [NUM_CH*ORDER_W-1:0] order,
    output logic                      halt,
    output logic [3:0]                errcode,
    output logic                      done
);
    logic [ORDER_W-1:0] base, next_base;
    logic [NUM_CH:0]    prev;
    logic [31:0]        idle;
    logic [15:0]        drain;
    logic [4:1]         mem_errs;
    logic               gap, hit, any, run, wd;
    errcode_t           err_q;

    mem_proto_checker #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_resp        (mem_resp),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .errs            (mem_errs)
    );

    // prev[i] is commit[i-1], with a virtual always-committing channel below ch0
    always_comb begin
        next_base = base;
        for (int i = 0; i < NUM_CH; i++) begin
            order[i*ORDER_W +: ORDER_W] = next_base;
            next_base = next_base + ORDER_W'(commit[i]);
        end
        prev = {commit, 1'b1};
        gap  = |(commit & ~prev[NUM_CH-1:0]);
        hit  = |(commit & halt_req);
        any  = |commit;
        run  = !halt && err_q == ERR_NONE;
        wd   = run && !any && idle == 32'(TIMEOUT - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base  <= '0;
            halt  <= 1'b0;
            idle  <= '0;
            err_q <= ERR_NONE;
            drain <= '0;
            done  <= 1'b0;
        end else begin
            if (!halt) base <= next_base;
            if (hit) halt <= 1'b1;
            if (any) idle <= '0;
            else if (run) idle <= idle + 32'd1;
            if (err_q == ERR_NONE) err_q <= first_err({wd, gap, mem_errs});
            if (err_q != ERR_NONE && !done) drain <= drain + 16'd1;
            if (halt || (err_q != ERR_NONE && drain == 16'(DRAIN - 1))) done <= 1'b1;
        end
    end

    assign errcode = err_q;
endmodule
